// File: rtl/hmac_ipad_feeder.sv
// hmac_ipad_feeder: inner-pass front end for HMAC-SHA1.
// Latches the key, bursts key^ipad into the SHA-1 core, then buffers the
// message into 16-word blocks, appends SHA-1 padding plus the 64-bit length
// (which includes the 64-byte ipad block) and bursts each block to the core.
// Optional feature macro: HMAC_PAD_BYTE_EN (honour msg_bytes on the final word).
module hmac_ipad_feeder #(
  parameter int LEN_W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [511:0] key,
  input  logic         start,
  input  logic [31:0]  msg_data,
  input  logic         msg_valid,
  input  logic         msg_last,
  input  logic [1:0]   msg_bytes,
  output logic         msg_ready,
  input  logic         sha_ready,
  output logic [31:0]  out_to_sha,
  output logic         sah_start,
  output logic         sha_first,
  output logic         busy,
  output logic         done
);

  typedef enum logic [2:0] {
    S_IDLE, S_KEYWAIT, S_KEYBURST, S_FILL, S_PAD, S_WAITRDY, S_BURST, S_DONE
  } state_t;

  state_t           r_state, w_nextState;
  logic [511:0]     r_key;
  logic [31:0]      r_buf [16];
  logic [3:0]       r_wi, r_cnt, w_nextCnt;
  logic [LEN_W-1:0] r_nbytes;
  logic             r_seenLow, r_markPending, r_lenOk, r_padPending, r_final;
  logic             r_msgReady, r_sahStart, r_shaFirst, r_busy, r_done;
  logic [31:0]      r_out;
  logic [31:0]      w_keyWords [16];
  logic [31:0]      w_wrData, w_padWord;
  logic [63:0]      w_len;
  logic [2:0]       w_lastBytes;
  logic [LEN_W-1:0] w_byteInc;
  logic             w_accept, w_go, w_burstStart, w_fullWord;

`ifdef HMAC_PAD_BYTE_EN
  assign w_lastBytes = (msg_bytes == 2'd0) ? 3'd4 : {1'b0, msg_bytes};

  // Final partial word: keep the valid bytes, place 0x80 right after them, zero the rest
  always_comb begin
    w_wrData = msg_data;
    if (msg_last) begin
      case (msg_bytes)
        2'd1:    w_wrData = {msg_data[31:24], 24'h800000};
        2'd2:    w_wrData = {msg_data[31:16], 16'h8000};
        2'd3:    w_wrData = {msg_data[31:8], 8'h80};
        default: w_wrData = msg_data;
      endcase
    end
  end
`else
  logic w_unusedBytes;
  assign w_unusedBytes = ^msg_bytes;
  assign w_lastBytes   = 3'd4;
  assign w_wrData      = msg_data;
`endif

  assign w_fullWord   = (w_lastBytes == 3'd4);
  assign w_byteInc    = LEN_W'(msg_last ? w_lastBytes : 3'd4);
  assign w_accept     = (r_state == S_FILL) && msg_valid;
  assign w_go         = sha_ready && r_seenLow;
  assign w_burstStart = ((r_state == S_KEYWAIT) || (r_state == S_WAITRDY)) && w_go;
  assign w_len        = (64'(r_nbytes) + 64'd64) << 3;

  // Key block words: each 32-bit slice of the latched key XOR the ipad constant
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      w_keyWords[i] = r_key[511 - 32*i -: 32] ^ 32'h36363636;
    end
  end

  // Word written into the buffer on each padding cycle
  always_comb begin
    w_padWord = 32'h0;
    if (r_markPending) begin
      w_padWord = 32'h80000000;
    end else if (r_lenOk && (r_wi == 4'd14)) begin
      w_padWord = w_len[63:32];
    end else if (r_lenOk && (r_wi == 4'd15)) begin
      w_padWord = w_len[31:0];
    end
  end

  // Next-state and burst word index selection
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = 4'd0;
    unique case (r_state)
      S_IDLE:     if (start) w_nextState = S_KEYWAIT;
      S_KEYWAIT:  if (w_go) w_nextState = S_KEYBURST;
      S_KEYBURST: begin
        if (r_cnt == 4'd15) w_nextState = S_FILL;
        else                w_nextCnt   = r_cnt + 4'd1;
      end
      S_FILL: begin
        if (w_accept) begin
          if (r_wi == 4'd15) w_nextState = S_WAITRDY;
          else if (msg_last) w_nextState = S_PAD;
        end
      end
      S_PAD:      if (r_wi == 4'd15) w_nextState = S_WAITRDY;
      S_WAITRDY:  if (w_go) w_nextState = S_BURST;
      S_BURST: begin
        if (r_cnt == 4'd15) begin
          if (r_final)           w_nextState = S_DONE;
          else if (r_padPending) w_nextState = S_PAD;
          else                   w_nextState = S_FILL;
        end else begin
          w_nextCnt = r_cnt + 4'd1;
        end
      end
      S_DONE:     w_nextState = S_IDLE;
      default:    w_nextState = S_IDLE;
    endcase
  end

  // State register, burst counter and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_out      <= 32'h0;
      r_sahStart <= 1'b0;
      r_shaFirst <= 1'b0;
      r_msgReady <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_cnt      <= w_nextCnt;
      r_out      <= (w_nextState == S_KEYBURST) ? w_keyWords[w_nextCnt] :
                    (w_nextState == S_BURST)    ? r_buf[w_nextCnt]      : 32'h0;
      r_sahStart <= (w_nextState == S_KEYBURST) || (w_nextState == S_BURST);
      r_shaFirst <= (w_nextState == S_KEYBURST);
      r_msgReady <= (w_nextState == S_FILL);
      r_busy     <= (w_nextState != S_IDLE);
      r_done     <= (w_nextState == S_DONE);
    end
  end

  // Key latch, write index, byte count and padding bookkeeping flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key         <= '0;
      r_wi          <= 4'd0;
      r_nbytes      <= '0;
      r_seenLow     <= 1'b1;
      r_markPending <= 1'b0;
      r_lenOk       <= 1'b0;
      r_padPending  <= 1'b0;
      r_final       <= 1'b0;
    end else begin
      if (w_burstStart)   r_seenLow <= 1'b0;
      else if (!sha_ready) r_seenLow <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_key         <= key;
            r_wi          <= 4'd0;
            r_nbytes      <= '0;
            r_markPending <= 1'b0;
            r_lenOk       <= 1'b0;
            r_padPending  <= 1'b0;
            r_final       <= 1'b0;
          end
        end
        S_FILL: begin
          if (w_accept) begin
            r_wi     <= r_wi + 4'd1;
            r_nbytes <= r_nbytes + w_byteInc;
            if (msg_last) begin
              r_markPending <= w_fullWord;
              if (r_wi == 4'd15) begin
                r_padPending <= 1'b1;
                r_lenOk      <= 1'b1;
              end else begin
                r_lenOk <= w_fullWord ? (r_wi <= 4'd12) : (r_wi <= 4'd13);
              end
            end
          end
        end
        S_PAD: begin
          r_wi          <= r_wi + 4'd1;
          r_markPending <= 1'b0;
          if (r_wi == 4'd15) begin
            if (r_lenOk) begin
              r_final <= 1'b1;
            end else begin
              r_padPending <= 1'b1;
              r_lenOk      <= 1'b1;
            end
          end
        end
        S_BURST: if (r_cnt == 4'd15) r_padPending <= 1'b0;
        default: ;
      endcase
    end
  end

  // Block buffer: message words during FILL, padding/length words during PAD
  always_ff @(posedge clk) begin
    if (w_accept)               r_buf[r_wi] <= w_wrData;
    else if (r_state == S_PAD)  r_buf[r_wi] <= w_padWord;
  end

  assign msg_ready  = r_msgReady;
  assign out_to_sha = r_out;
  assign sah_start  = r_sahStart;
  assign sha_first  = r_shaFirst;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_hmac_ipad_feeder.sv
// tb_hmac_ipad_feeder: randomized self-checking bench for hmac_ipad_feeder.
// A byte-level SHA-1 padding model builds the expected word stream; a small
// core model drops sha_ready after every burst so each burst is handshaken.
module tb_hmac_ipad_feeder;

`ifdef HMAC_PAD_BYTE_EN
  localparam bit BYTE_EN = 1'b1;
`else
  localparam bit BYTE_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [511:0] key = '0;
  logic         start = 1'b0;
  logic [31:0]  msg_data = 32'h0;
  logic         msg_valid = 1'b0;
  logic         msg_last = 1'b0;
  logic [1:0]   msg_bytes = 2'd0;
  logic         msg_ready;
  logic         sha_ready;
  logic [31:0]  out_to_sha;
  logic         sah_start, sha_first, busy, done;

  int passCount = 0;
  int checkCount = 0;
  int runLen = 0;
  int coreBusyCnt = 0;
  bit holdLow = 1'b0;

  logic [31:0] msgWords[$];
  logic [1:0]  msgLastBytes;
  logic [31:0] expWords[$];
  logic [31:0] gotWords[$];
  logic        gotFirst[$];

  hmac_ipad_feeder dut (
    .clk(clk), .rst_n(rst_n), .key(key), .start(start),
    .msg_data(msg_data), .msg_valid(msg_valid), .msg_last(msg_last),
    .msg_bytes(msg_bytes), .msg_ready(msg_ready), .sha_ready(sha_ready),
    .out_to_sha(out_to_sha), .sah_start(sah_start), .sha_first(sha_first),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  assign sha_ready = !holdLow && (coreBusyCnt == 0);

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  // Core model and stream capture: record every burst word, check burst length,
  // and hold sha_ready low for a few cycles after each burst word is seen
  always @(negedge clk) begin
    if (!rst_n) begin
      runLen = 0;
      coreBusyCnt = 0;
    end else if (sah_start) begin
      gotWords.push_back(out_to_sha);
      gotFirst.push_back(sha_first);
      runLen++;
      coreBusyCnt = 2 + int'($urandom_range(0, 3));
    end else begin
      if (runLen != 0) begin
        checkOutput("burst_len", 64'(runLen), 64'd16);
        runLen = 0;
      end
      if (coreBusyCnt > 0) coreBusyCnt--;
    end
  end

  task automatic makeMsg(input int nbytes);
    msgWords.delete();
    for (int i = 0; i < (nbytes + 3) / 4; i++) msgWords.push_back($urandom);
    msgLastBytes = 2'(nbytes % 4);
  endtask

  // Reference: key^ipad block, then message bytes + 0x80 + zeros + 64-bit bit length
  task automatic buildExpected(input logic [511:0] k);
    byte unsigned bq[$];
    logic [31:0]  wd;
    logic [63:0]  lenBits;
    int           effLast;
    expWords.delete();
    for (int i = 0; i < 16; i++) expWords.push_back(k[511 - 32*i -: 32] ^ 32'h36363636);
    effLast = (BYTE_EN && msgLastBytes != 2'd0) ? int'(msgLastBytes) : 4;
    for (int w = 0; w < msgWords.size(); w++) begin
      wd = msgWords[w];
      for (int b = 0; b < 4; b++)
        if (w < msgWords.size() - 1 || b < effLast) bq.push_back(wd[31 - 8*b -: 8]);
    end
    lenBits = 64'(64 + bq.size()) * 64'd8;
    bq.push_back(8'h80);
    while (bq.size() % 64 != 56) bq.push_back(8'h00);
    for (int b = 7; b >= 0; b--) bq.push_back(lenBits[8*b +: 8]);
    for (int j = 0; j < bq.size(); j += 4)
      expWords.push_back({bq[j], bq[j+1], bq[j+2], bq[j+3]});
  endtask

  function automatic logic [511:0] randKey();
    logic [511:0] k;
    for (int i = 0; i < 16; i++) k[32*i +: 32] = $urandom;
    return k;
  endfunction

  task automatic startTask(input logic [511:0] k);
    @(negedge clk);
    key = k;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("keywait_busy", 64'(busy), 64'd1);
    checkOutput("keywait_sah", 64'(sah_start), 64'd0);
    checkOutput("keywait_ready", 64'(msg_ready), 64'd0);
  endtask

  // Drive message words fromIdx..toIdx with random valid gaps
  task automatic applyStimulus(input int fromIdx, input int toIdx);
    int waitCyc;
    for (int w = fromIdx; w <= toIdx; w++) begin
      while ($urandom_range(0, 2) == 0) begin
        msg_valid = 1'b0;
        @(negedge clk);
      end
      msg_data  = msgWords[w];
      msg_last  = (w == msgWords.size() - 1);
      msg_bytes = msg_last ? msgLastBytes : 2'($urandom);
      msg_valid = 1'b1;
      waitCyc = 0;
      while (msg_ready !== 1'b1 && waitCyc < 400) begin
        @(negedge clk);
        waitCyc++;
      end
      if (msg_ready !== 1'b1) begin
        checkOutput("accept_wait", 64'(msg_ready), 64'd1);
        msg_valid = 1'b0;
        msg_last  = 1'b0;
        return;
      end
      @(negedge clk);
    end
    msg_valid = 1'b0;
    msg_last  = 1'b0;
  endtask

  task automatic waitDone(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_done"}, 64'(done), 64'd1);
    checkOutput({tag, "_busy_at_done"}, 64'(busy), 64'd1);
    @(negedge clk);
    checkOutput({tag, "_done_pulse"}, 64'(done), 64'd0);
    checkOutput({tag, "_busy_after"}, 64'(busy), 64'd0);
  endtask

  task automatic compareStreams(input string tag);
    checkOutput({tag, "_count"}, 64'(gotWords.size()), 64'(expWords.size()));
    for (int i = 0; i < expWords.size() && i < gotWords.size(); i++) begin
      checkOutput($sformatf("%s_w%0d", tag, i), 64'(gotWords[i]), 64'(expWords[i]));
      checkOutput($sformatf("%s_first%0d", tag, i), 64'(gotFirst[i]), 64'(i < 16));
    end
  endtask

  task automatic runMessage(input string tag, input logic [511:0] k, input bit preValid);
    gotWords.delete();
    gotFirst.delete();
    buildExpected(k);
    if (preValid) begin
      msg_data  = msgWords[0];
      msg_last  = (msgWords.size() == 1);
      msg_bytes = msgLastBytes;
      msg_valid = 1'b1;
    end
    startTask(k);
    applyStimulus(0, msgWords.size() - 1);
    waitDone(tag);
    compareStreams(tag);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [511:0] k;
    int n;

    // Reset values
    repeat (2) @(negedge clk);
    checkOutput("rst_out", 64'(out_to_sha), 64'd0);
    checkOutput("rst_sah", 64'(sah_start), 64'd0);
    checkOutput("rst_first", 64'(sha_first), 64'd0);
    checkOutput("rst_ready", 64'(msg_ready), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Zero key and "abc": key burst must start two cycles after start
    gotWords.delete();
    gotFirst.delete();
    msgWords.delete();
    msgWords.push_back(32'h61626300);
    msgLastBytes = 2'd3;
    buildExpected('0);
    startTask('0);
    @(negedge clk);
    checkOutput("key_start_sah", 64'(sah_start), 64'd1);
    checkOutput("key_start_first", 64'(sha_first), 64'd1);
    checkOutput("key_word0", 64'(out_to_sha), 64'h36363636);
    applyStimulus(0, 0);
    waitDone("abc");
    compareStreams("abc");

    // 56-byte message: length spills into a second padding block
    makeMsg(56);
    runMessage("ovf56", randKey(), 1'b0);

    // Core backpressure after the first full block
    makeMsg(83);
    k = randKey();
    gotWords.delete();
    gotFirst.delete();
    buildExpected(k);
    startTask(k);
    n = 0;
    while (msg_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    holdLow = 1'b1;
    applyStimulus(0, 15);
    for (int c = 0; c < 50; c++) begin
      checkOutput("bp_sah", 64'(sah_start), 64'd0);
      checkOutput("bp_ready", 64'(msg_ready), 64'd0);
      @(negedge clk);
    end
    holdLow = 1'b0;
    @(negedge clk);
    checkOutput("bp_release_sah", 64'(sah_start), 64'd1);
    applyStimulus(16, msgWords.size() - 1);
    waitDone("bp");
    compareStreams("bp");

    // Randomized lengths, keys and valid gaps; one with msg_valid raised alongside start
    for (int t = 0; t < 5; t++) begin
      makeMsg(int'($urandom_range(1, 150)));
      runMessage($sformatf("rnd%0d", t), randKey(), t == 2);
    end
    makeMsg(64);
    runMessage("len64", randKey(), 1'b0);
    makeMsg(55);
    runMessage("len55", randKey(), 1'b0);

    // Reset in the middle of the key burst, then a clean computation
    gotWords.delete();
    gotFirst.delete();
    startTask(randKey());
    n = 0;
    while (gotWords.size() < 7 && n < 100) begin
      @(negedge clk);
      n++;
    end
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_sah", 64'(sah_start), 64'd0);
    checkOutput("midrst_busy", 64'(busy), 64'd0);
    checkOutput("midrst_ready", 64'(msg_ready), 64'd0);
    checkOutput("midrst_first", 64'(sha_first), 64'd0);
    checkOutput("midrst_out", 64'(out_to_sha), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    makeMsg(21);
    runMessage("postrst", randKey(), 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
